uart_tx_fsm: RTL
================

Name: uart_tx_fsm

Overview:
UART transmitter, the companion to the oversampled UART receiver. It accepts a parallel word through a valid/busy handshake and serialises one frame on TX_OUT: start bit, DATA_WIDTH data bits LSB first, an optional even/odd parity bit, and one stop bit. It runs on the receiver's oversampled clock, so each bit is held for PRESCALE CLK cycles. It sits between the system-side data producer and the serial line.

Parameters:
DATA_WIDTH, 8, payload width in bits (1..15)
PRESCALE, 8, CLK cycles per bit period (>=2); matches the receiver oversampling ratio

Ports:
CLK  input  1  clock
RST  input  1  reset, asynchronous, active-low
P_DATA  input  DATA_WIDTH  parallel word to send
DATA_VALID  input  1  word on P_DATA is valid
PAR_EN  input  1  1 = insert parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
TX_OUT  output  1  serial line, idles high
BUSY  output  1  frame in progress; DATA_VALID is ignored while high

Behaviour:
- Reset: on RST low, immediately and asynchronously:
  - state IDLE, TX_OUT=1, BUSY=0
  - counters and shift register cleared
  - reset mid-frame aborts the frame with no partial recovery
- All outputs are registered; TX_OUT and BUSY have no combinational path from inputs.
- State encoding: IDLE 000, START 001, DATA 011, PARITY 010, STOP 110. Illegal codes go to IDLE with TX_OUT=1 and BUSY=0.
- Acceptance happens only when state is IDLE and DATA_VALID=1, sampled on the rising edge.
  - At that edge, P_DATA, PAR_EN and PAR_TYP are latched.
  - Parity bit = ^P_DATA when PAR_TYP=0, or ~^P_DATA when PAR_TYP=1, computed from the latched data.
  - Next state START; TX_OUT=0 and BUSY=1 from the following cycle (1-cycle latency).
- DATA_VALID=1 while BUSY=1 is dropped, not queued. Changes to P_DATA, PAR_EN or PAR_TYP mid-frame have no effect.
- Prescale counter, width $clog2(PRESCALE):
  - counts 0..PRESCALE-1 within each bit period, then wraps
  - a bit period ends when the counter equals PRESCALE-1
- Bit counter: 4 bits, indexes data bits 0..DATA_WIDTH-1.
- State transitions, each taken at the end of a bit period:
  - START: to DATA.
  - DATA: TX_OUT = shift_reg[0]; shift right at the end of each bit period. After bit DATA_WIDTH-1, go to PARITY if latched PAR_EN=1, else STOP.
  - PARITY: TX_OUT = latched parity bit; then STOP.
  - STOP: TX_OUT=1; then IDLE, with BUSY=0 from the next cycle.
- Frame length with BUSY=1 is PRESCALE*(DATA_WIDTH+2+PAR_EN) cycles exactly.
- Back-to-back frames:
  - a DATA_VALID held high through the end of STOP is accepted on the first IDLE cycle
  - minimum gap between frames is 1 CLK of idle-high line
- TX_OUT never glitches within a bit period; it changes only on the wrap of the prescale counter or on the acceptance edge.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants (shared with the receiver FSM)
  - PAR_EVEN=0 and PAR_ODD=1
  - default DATA_WIDTH and PRESCALE values
- One natural sub-module: uart_tx_baud_cnt.
  - Contents: prescale counter plus bit counter.
  - Inputs: clear and enable.
  - Outputs: bit_done and bit_idx.
- FSM, shift register and parity logic stay in uart_tx_fsm.

Test Plan:
- PRESCALE=8, P_DATA=0xA5, PAR_EN=0, one-cycle DATA_VALID -> TX_OUT bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 8 CLKs; BUSY high for exactly 80 cycles, starting 1 cycle after acceptance; TX_OUT=1 afterwards.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0, frame 88 cycles. Same data with PAR_TYP=1 -> parity bit 1. P_DATA=0x01 even -> parity bit 1.
- DATA_VALID pulsed with P_DATA=0x3C at cycle 20 of an ongoing 0xA5 frame -> ignored: 0xA5 frame is unchanged and no second frame follows.
- DATA_VALID held high with 0x55 then 0xAA -> two complete frames separated by exactly 1 idle-high CLK; both decode correctly through the existing receiver in loopback.
- RST asserted during the DATA state at bit 3 -> TX_OUT=1 and BUSY=0 asynchronously; after release, a new 0x0F frame transmits correctly from START.
- Loopback against uart_rx over all 256 values x PAR_EN x PAR_TYP -> receiver data_valid fires for every frame with matching data and no par_err or stp_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver FSMs: state codes,
// parity selectors, default frame geometry and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b011,
    ST_PARITY = 3'b010,
    ST_STOP   = 3'b110
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_PRESCALE   = 8;

  // Zero-extension of narrower words leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [15:0] data, input logic typ);
    return (typ == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period timing for the UART transmitter: prescale counter marking the end
// of each bit period, and a bit counter indexing the current data bit.
module uart_tx_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clear_i,
  input  logic       enable_i,
  output logic       bit_done_o,
  output logic [3:0] bit_idx_o
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;

  assign bit_done_o = enable_i && (cnt_q == LAST);
  assign bit_idx_o  = bit_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
      bit_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
      bit_q <= '0;
    end else if (enable_i) begin
      if (cnt_q == LAST) begin
        cnt_q <= '0;
        bit_q <= bit_q + 4'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: accepts a word on DATA_VALID while idle and serialises
// start, LSB-first data, optional parity and stop bits, PRESCALE clocks each.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PRESCALE   = DEF_PRESCALE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  uart_state_e           state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_nx;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  tx_q;
  logic                  busy_q;

  logic       bit_done;
  logic [3:0] bit_idx;
  logic       cnt_en;
  logic       cnt_clear;

  // The bit counter is restarted on entry to DATA so bit_idx names the data bit.
  assign cnt_en    = (state_q != ST_IDLE);
  assign cnt_clear = !cnt_en || ((state_q == ST_START) && bit_done);
  assign shift_nx  = shift_q >> 1;

  uart_tx_baud_cnt #(
    .PRESCALE(PRESCALE)
  ) u_baud (
    .CLK       (CLK),
    .RST       (RST),
    .clear_i   (cnt_clear),
    .enable_i  (cnt_en),
    .bit_done_o(bit_done),
    .bit_idx_o (bit_idx)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (DATA_VALID) begin
            state_q   <= ST_START;
            shift_q   <= P_DATA;
            par_en_q  <= PAR_EN;
            par_bit_q <= calc_parity(16'(P_DATA), PAR_TYP);
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_done) begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            shift_q <= shift_nx;
            if (bit_idx == LAST_BIT) begin
              if (par_en_q) begin
                state_q <= ST_PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              tx_q <= shift_nx[0];
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule
